// File: rtl/sprite_compositor_pipe.sv
// Pipelined sprite compositor for the VGA path.
// Stage 1 performs the hit tests against the frame-latched shadow positions and
// registers the sprite-ROM addresses. Stage 2 waits for the ROM colours while
// the hit flags travel alongside them. Stage 3 blends the colours with the
// transparency keys and accumulates per-frame player/object collisions.
module sprite_compositor_pipe #(
    parameter int          NUM_OBJ      = 24,
    parameter int          OBJ_W        = 20,
    parameter int          OBJ_H        = 20,
    parameter int          MAN_W        = 20,
    parameter int          MAN_H        = 20,
    parameter int          BAN_W        = 320,
    parameter int          BAN_H        = 64,
    parameter logic [11:0] SPR_KEY      = 12'hFFF,
    parameter logic [11:0] BAN_KEY      = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      Frame_Start,
    input  logic                      Pix_Valid,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [9:0]                ManX,
    input  logic [9:0]                ManY,
    input  logic [NUM_OBJ-1:0][9:0]   ObjX,
    input  logic [NUM_OBJ-1:0][9:0]   ObjY,
    input  logic [NUM_OBJ-1:0]        ObjEn,
    input  logic                      Dead,
    input  logic                      Win,
    input  logic [9:0]                BanX,
    input  logic [9:0]                BanY,
    output logic                      Obj_Hit,
    output logic [4:0]                Obj_Idx,
    output logic [4:0]                Obj_U,
    output logic [4:0]                Obj_V,
    output logic                      Man_Hit,
    output logic [4:0]                Man_U,
    output logic [4:0]                Man_V,
    output logic [1:0]                Ban_Sel,
    output logic [8:0]                Ban_U,
    output logic [5:0]                Ban_V,
    input  logic [11:0]               Obj_RGB,
    input  logic [11:0]               Man_RGB,
    input  logic [11:0]               Ban_RGB,
    input  logic [11:0]               Bkg_RGB,
    output logic [11:0]               RGB,
    output logic                      RGB_Valid,
    output logic                      Collide,
    output logic [4:0]                Collide_Idx
);

    localparam int unsigned BLK_TOP = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;

    // Frame-latched copies of the scene description
    logic [9:0]               r_man_x, r_man_y, r_ban_x, r_ban_y;
    logic [NUM_OBJ-1:0][9:0]  r_obj_x, r_obj_y;
    logic [NUM_OBJ-1:0]       r_obj_en;
    logic                     r_dead, r_win;
    // Banner blink state
    logic [15:0]              r_blk_cnt;
    logic                     r_blk_hidden;
    // Pipeline side-band
    logic                     r1_valid, r1_ban_show;
    logic                     r2_valid, r2_ban_show, r2_man_hit, r2_obj_hit;
    logic [4:0]               r2_obj_idx;
    // Collision tracking within the current frame
    logic                     r_coll_sticky;
    logic [4:0]               r_coll_idx;

    logic                     w_obj_hit, w_man_hit, w_ban_in, w_coll;
    logic [4:0]               w_obj_idx, w_obj_u, w_obj_v;
    logic [1:0]               w_ban_sel;
    logic [11:0]              w_rgb;

    // Inclusive-low/exclusive-high span test done in 11 bits so that a sprite
    // placed near 1023 cannot wrap around and hit small coordinates
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] o, input int w);
        return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} < ({1'b0, o} + 11'(w)));
    endfunction

    // Shadow latch and banner blink counter, both advanced by Frame_Start
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_man_x      <= '0;
            r_man_y      <= '0;
            r_ban_x      <= '0;
            r_ban_y      <= '0;
            r_obj_x      <= '0;
            r_obj_y      <= '0;
            r_obj_en     <= '0;
            r_dead       <= 1'b0;
            r_win        <= 1'b0;
            r_blk_cnt    <= '0;
            r_blk_hidden <= 1'b0;
        end else if (Frame_Start) begin
            r_man_x  <= ManX;
            r_man_y  <= ManY;
            r_ban_x  <= BanX;
            r_ban_y  <= BanY;
            r_obj_x  <= ObjX;
            r_obj_y  <= ObjY;
            r_obj_en <= ObjEn;
            r_dead   <= Dead;
            r_win    <= Win;
            // A frame is counted when it ends with a banner request active;
            // a request dropping to none restarts the cycle in the visible phase
            if (!(Dead || Win)) begin
                r_blk_cnt    <= '0;
                r_blk_hidden <= 1'b0;
            end else if ((r_dead || r_win) && (BLINK_FRAMES > 0)) begin
                if (r_blk_cnt == 16'(BLK_TOP)) begin
                    r_blk_cnt    <= '0;
                    r_blk_hidden <= ~r_blk_hidden;
                end else begin
                    r_blk_cnt <= r_blk_cnt + 16'd1;
                end
            end
        end
    end

    // Stage-1 hit tests; lowest enabled object index wins
    always_comb begin
        w_obj_hit = 1'b0;
        w_obj_idx = '0;
        w_obj_u   = '0;
        w_obj_v   = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (!w_obj_hit && r_obj_en[i] &&
                in_span(DrawX, r_obj_x[i], OBJ_W) && in_span(DrawY, r_obj_y[i], OBJ_H)) begin
                w_obj_hit = 1'b1;
                w_obj_idx = 5'(i);
                w_obj_u   = 5'(DrawX - r_obj_x[i]);
                w_obj_v   = 5'(DrawY - r_obj_y[i]);
            end
        end
        w_man_hit = in_span(DrawX, r_man_x, MAN_W) && in_span(DrawY, r_man_y, MAN_H);
        w_ban_in  = in_span(DrawX, r_ban_x, BAN_W) && in_span(DrawY, r_ban_y, BAN_H);
        w_ban_sel = r_win ? 2'd2 : (r_dead ? 2'd1 : 2'd0);
    end

    // Stage-1 address registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Obj_Hit     <= 1'b0;
            Obj_Idx     <= '0;
            Obj_U       <= '0;
            Obj_V       <= '0;
            Man_Hit     <= 1'b0;
            Man_U       <= '0;
            Man_V       <= '0;
            Ban_Sel     <= '0;
            Ban_U       <= '0;
            Ban_V       <= '0;
            r1_valid    <= 1'b0;
            r1_ban_show <= 1'b0;
        end else begin
            Obj_Hit     <= w_obj_hit;
            Obj_Idx     <= w_obj_idx;
            Obj_U       <= w_obj_u;
            Obj_V       <= w_obj_v;
            Man_Hit     <= w_man_hit;
            Man_U       <= 5'(DrawX - r_man_x);
            Man_V       <= 5'(DrawY - r_man_y);
            Ban_Sel     <= w_ban_sel;
            Ban_U       <= 9'(DrawX - r_ban_x);
            Ban_V       <= 6'(DrawY - r_ban_y);
            r1_valid    <= Pix_Valid;
            r1_ban_show <= w_ban_in && (w_ban_sel != 2'd0) && !r_blk_hidden;
        end
    end

    // Stage-2 delay of the hit flags so they line up with the ROM colours
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r2_valid    <= 1'b0;
            r2_ban_show <= 1'b0;
            r2_man_hit  <= 1'b0;
            r2_obj_hit  <= 1'b0;
            r2_obj_idx  <= '0;
        end else begin
            r2_valid    <= r1_valid;
            r2_ban_show <= r1_ban_show;
            r2_man_hit  <= Man_Hit;
            r2_obj_hit  <= Obj_Hit;
            r2_obj_idx  <= Obj_Idx;
        end
    end

    // Stage-3 layer blend: a keyed pixel falls through to the layer beneath
    always_comb begin
        w_rgb = Bkg_RGB;
        if (!r2_valid)
            w_rgb = '0;
        else if (r2_ban_show && (Ban_RGB != BAN_KEY))
            w_rgb = Ban_RGB;
        else if (r2_man_hit && (Man_RGB != SPR_KEY))
            w_rgb = Man_RGB;
        else if (r2_obj_hit && (Obj_RGB != SPR_KEY))
            w_rgb = Obj_RGB;
        w_coll = r2_valid && r2_man_hit && (Man_RGB != SPR_KEY) &&
                 r2_obj_hit && (Obj_RGB != SPR_KEY);
    end

    // Stage-3 output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RGB       <= '0;
            RGB_Valid <= 1'b0;
        end else begin
            RGB       <= w_rgb;
            RGB_Valid <= r2_valid;
        end
    end

    // Collision report: publish at Frame_Start, then restart accumulation
    // with any overlap seen in that same cycle counted toward the new frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Collide       <= 1'b0;
            Collide_Idx   <= '0;
            r_coll_sticky <= 1'b0;
            r_coll_idx    <= '0;
        end else if (Frame_Start) begin
            Collide       <= r_coll_sticky;
            Collide_Idx   <= r_coll_idx;
            r_coll_sticky <= w_coll;
            r_coll_idx    <= w_coll ? r2_obj_idx : 5'd0;
        end else if (w_coll && !r_coll_sticky) begin
            r_coll_sticky <= 1'b1;
            r_coll_idx    <= r2_obj_idx;
        end
    end

endmodule

// File: tb/tb_sprite_compositor_pipe.sv
// Directed bench for sprite_compositor_pipe. Expected colours are queued when
// a pixel is driven and popped when RGB_Valid comes out; stage-1 addresses are
// checked one clock after each pixel.
module tb_sprite_compositor_pipe;

    localparam int N = 8;

    logic              Clk = 1'b0;
    logic              Reset_n, Frame_Start, Pix_Valid, Dead, Win;
    logic [9:0]        DrawX, DrawY, ManX, ManY, BanX, BanY;
    logic [N-1:0][9:0] ObjX, ObjY;
    logic [N-1:0]      ObjEn;
    logic              Obj_Hit, Man_Hit, RGB_Valid, Collide;
    logic [4:0]        Obj_Idx, Obj_U, Obj_V, Man_U, Man_V, Collide_Idx;
    logic [1:0]        Ban_Sel;
    logic [8:0]        Ban_U;
    logic [5:0]        Ban_V;
    logic [11:0]       Obj_RGB, Man_RGB, Ban_RGB, Bkg_RGB, RGB;

    // Colours chosen per pixel, delayed two clocks to mimic a synchronous ROM
    logic [11:0] c_obj, c_man, c_ban, c_bkg;
    logic [11:0] p1_obj, p1_man, p1_ban, p1_bkg;
    logic [11:0] p2_obj = '0, p2_man = '0, p2_ban = '0, p2_bkg = '0;

    logic [11:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        p1_obj <= c_obj; p1_man <= c_man; p1_ban <= c_ban; p1_bkg <= c_bkg;
        p2_obj <= p1_obj; p2_man <= p1_man; p2_ban <= p1_ban; p2_bkg <= p1_bkg;
    end
    assign Obj_RGB = p2_obj;
    assign Man_RGB = p2_man;
    assign Ban_RGB = p2_ban;
    assign Bkg_RGB = p2_bkg;

    sprite_compositor_pipe #(.NUM_OBJ(N), .BLINK_FRAMES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Start(Frame_Start), .Pix_Valid(Pix_Valid),
        .DrawX(DrawX), .DrawY(DrawY), .ManX(ManX), .ManY(ManY),
        .ObjX(ObjX), .ObjY(ObjY), .ObjEn(ObjEn), .Dead(Dead), .Win(Win),
        .BanX(BanX), .BanY(BanY),
        .Obj_Hit(Obj_Hit), .Obj_Idx(Obj_Idx), .Obj_U(Obj_U), .Obj_V(Obj_V),
        .Man_Hit(Man_Hit), .Man_U(Man_U), .Man_V(Man_V),
        .Ban_Sel(Ban_Sel), .Ban_U(Ban_U), .Ban_V(Ban_V),
        .Obj_RGB(Obj_RGB), .Man_RGB(Man_RGB), .Ban_RGB(Ban_RGB), .Bkg_RGB(Bkg_RGB),
        .RGB(RGB), .RGB_Valid(RGB_Valid), .Collide(Collide), .Collide_Idx(Collide_Idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every valid pixel pops one expectation; idle output is black
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (RGB_Valid) begin
                if (sb_q.size() == 0)
                    chk("sb_unexpected_valid", 32'(RGB_Valid), 32'd0);
                else
                    chk("sb_rgb", 32'(RGB), 32'(sb_q.pop_front()));
            end else begin
                chk("rgb_idle_black", 32'(RGB), 32'h000);
            end
        end
    end

    // Drive one active pixel with its ROM colours and queue the expected output
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [11:0] oc,
                       input logic [11:0] mc, input logic [11:0] bc, input logic [11:0] kc,
                       input logic [11:0] exp);
        DrawX = x; DrawY = y; Pix_Valid = 1'b1;
        c_obj = oc; c_man = mc; c_ban = bc; c_bkg = kc;
        sb_q.push_back(exp);
        @(negedge Clk);
        Pix_Valid = 1'b0;
        c_obj = '0; c_man = '0; c_ban = '0; c_bkg = '0;
    endtask

    task automatic fs();
        Frame_Start = 1'b1;
        @(negedge Clk);
        Frame_Start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Single pixel after an empty scene: RGB must appear exactly three clocks later
    task automatic latency(input logic [11:0] bkg);
        ObjEn = '0; Dead = 1'b0; Win = 1'b0; ManX = 10'd1000; ManY = 10'd1000;
        fs();
        pix(10'd5, 10'd0, 12'h000, 12'h000, 12'h000, bkg, bkg);
        chk("lat_n1_valid", 32'(RGB_Valid), 32'd0);
        @(negedge Clk);
        chk("lat_n2_valid", 32'(RGB_Valid), 32'd0);
        @(negedge Clk);
        chk("lat_n3_valid", 32'(RGB_Valid), 32'd1);
        chk("lat_n3_rgb", 32'(RGB), 32'(bkg));
        idle(2);
    endtask

    initial begin
        logic vis_tab [7];
        vis_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        Reset_n = 1'b0; Frame_Start = 1'b0; Pix_Valid = 1'b0;
        DrawX = '0; DrawY = '0; ManX = '0; ManY = '0; BanX = '0; BanY = '0;
        ObjX = '0; ObjY = '0; ObjEn = '0; Dead = 1'b0; Win = 1'b0;
        c_obj = '0; c_man = '0; c_ban = '0; c_bkg = '0;
        idle(3);
        chk("rst_rgb", 32'(RGB), 32'd0);
        chk("rst_valid", 32'(RGB_Valid), 32'd0);
        chk("rst_collide", 32'(Collide), 32'd0);
        chk("rst_ban_sel", 32'(Ban_Sel), 32'd0);
        Reset_n = 1'b1;
        idle(1);

        latency(12'h123);

        // Priority and transparency: obj0 and obj3 stacked
        ObjX[0] = 10'd100; ObjY[0] = 10'd100; ObjX[3] = 10'd100; ObjY[3] = 10'd100;
        ObjEn = 8'b0000_1001;
        fs();
        pix(10'd105, 10'd105, 12'hFFF, 12'h000, 12'h000, 12'h123, 12'h123);
        chk("prio_hit", 32'(Obj_Hit), 32'd1);
        chk("prio_idx", 32'(Obj_Idx), 32'd0);
        chk("prio_u", 32'(Obj_U), 32'd5);
        chk("prio_v", 32'(Obj_V), 32'd5);
        pix(10'd105, 10'd105, 12'hF00, 12'h000, 12'h000, 12'h123, 12'hF00);
        ObjEn = 8'b0000_1000;
        fs();
        pix(10'd105, 10'd105, 12'h0A0, 12'h000, 12'h000, 12'h123, 12'h0A0);
        chk("prio_idx3", 32'(Obj_Idx), 32'd3);

        // No wrap at the right edge
        ObjEn = 8'b0000_0001; ObjX[0] = 10'd1015; ObjY[0] = 10'd0;
        fs();
        pix(10'd3, 10'd5, 12'h00F, 12'h000, 12'h000, 12'h123, 12'h123);
        chk("edge_nowrap", 32'(Obj_Hit), 32'd0);
        pix(10'd1020, 10'd5, 12'h00F, 12'h000, 12'h000, 12'h123, 12'h00F);
        chk("edge_hit", 32'(Obj_Hit), 32'd1);
        chk("edge_u", 32'(Obj_U), 32'd5);

        // Shadow latch of the player position
        ObjEn = '0; ManX = 10'd50; ManY = 10'd0;
        fs();
        pix(10'd55, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h0F0);
        chk("shadow_hit50", 32'(Man_Hit), 32'd1);
        chk("shadow_u", 32'(Man_U), 32'd5);
        chk("shadow_v", 32'(Man_V), 32'd5);
        ManX = 10'd200;
        pix(10'd55, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h0F0);
        chk("shadow_still50", 32'(Man_Hit), 32'd1);
        pix(10'd205, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h123);
        chk("shadow_not200", 32'(Man_Hit), 32'd0);
        fs();
        pix(10'd205, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h0F0);
        chk("shadow_hit200", 32'(Man_Hit), 32'd1);
        pix(10'd55, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h123);
        chk("shadow_not50", 32'(Man_Hit), 32'd0);
        pix(10'd219, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h0F0);
        chk("shadow_last_col", 32'(Man_Hit), 32'd1);
        pix(10'd220, 10'd5, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h123);
        chk("shadow_past_end", 32'(Man_Hit), 32'd0);

        // Collision between player and obj7
        ManX = 10'd300; ManY = 10'd300; ObjX[7] = 10'd300; ObjY[7] = 10'd300;
        ObjEn = 8'b1000_0000;
        fs();
        pix(10'd305, 10'd305, 12'h00F, 12'h0F0, 12'h000, 12'h123, 12'h0F0);
        chk("coll_idx_s1", 32'(Obj_Idx), 32'd7);
        pix(10'd306, 10'd305, 12'h00F, 12'hFFF, 12'h000, 12'h123, 12'h00F);
        idle(4);
        chk("coll_pre", 32'(Collide), 32'd0);
        fs();
        chk("coll_set", 32'(Collide), 32'd1);
        chk("coll_idx", 32'(Collide_Idx), 32'd7);
        pix(10'd306, 10'd305, 12'h00F, 12'hFFF, 12'h000, 12'h123, 12'h00F);
        idle(4);
        fs();
        chk("coll_clear", 32'(Collide), 32'd0);

        // Banner blink with a half-period of two frames
        ObjEn = '0; ManX = 10'd1000; ManY = 10'd1000; BanX = 10'd0; BanY = 10'd0;
        Dead = 1'b1;
        for (int f = 0; f < 7; f++) begin
            fs();
            pix(10'd15, 10'd12, 12'h000, 12'h000, 12'h0F0, 12'h123,
                vis_tab[f] ? 12'h0F0 : 12'h123);
            chk($sformatf("blink_sel_f%0d", f + 1), 32'(Ban_Sel), 32'd1);
        end
        chk("ban_u", 32'(Ban_U), 32'd15);
        chk("ban_v", 32'(Ban_V), 32'd12);
        Dead = 1'b0;
        fs();
        pix(10'd15, 10'd12, 12'h000, 12'h000, 12'h0F0, 12'h123, 12'h123);
        chk("blink_none_sel", 32'(Ban_Sel), 32'd0);
        Dead = 1'b1;
        fs();
        pix(10'd15, 10'd12, 12'h000, 12'h000, 12'h0F0, 12'h123, 12'h0F0);
        pix(10'd15, 10'd12, 12'h000, 12'h000, 12'h000, 12'h123, 12'h123);
        Win = 1'b1;
        fs();
        pix(10'd15, 10'd12, 12'h000, 12'h000, 12'h0F0, 12'h123, 12'h0F0);
        chk("win_beats_dead", 32'(Ban_Sel), 32'd2);
        Dead = 1'b0; Win = 1'b0;
        idle(4);

        // Asynchronous reset with pixels in flight
        fs();
        pix(10'd5, 10'd5, 12'h000, 12'h000, 12'h000, 12'h456, 12'h456);
        pix(10'd6, 10'd5, 12'h000, 12'h000, 12'h000, 12'h456, 12'h456);
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(RGB_Valid), 32'd0);
        chk("midrst_rgb", 32'(RGB), 32'd0);
        sb_q.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(1);
        latency(12'h321);

        idle(4);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
